xadc_axil_seq_master: RTL and testbench
=======================================

// Module: xadc_axil_seq_master
// PURPOSE
//  AXI4-Lite read master that sweeps up to NUM_CH XADC result registers per conversion trigger
//  and emits each as a tagged sample on a valid/ready stream. Sits between the XADC Wizard AXI
//  slave and capture/trigger logic; generalises the single-channel eoc/val/state poller to N
//  masked channels with backpressure, overrun detection and a selectable trigger mode.
// PARAMETERS
//  NUM_CH       4       channels swept, 1..16; CH_W = max(1,$clog2(NUM_CH))
//  CH_BASE      12'h240 AXI byte address of channel 0 result register (VAUX0)
//  CH_STRIDE    4       byte offset between consecutive channel registers
//  ADDR_W       12      AXI address width
//  SAMPLE_W     12      sample width, taken from rdata[15 -: SAMPLE_W]
//  TRIG_MODE    0       0 = sweep on eoc_i pulse, 1 = free-run (re-sweep whenever idle and en_i)
// PORTS
//  clk            in   1         system clock
//  rst            in   1         asynchronous reset, active-high
//  en_i           in   1         sweep enable
//  eoc_i          in   1         XADC end-of-conversion, 1-cycle pulse, synchronous to clk
//  ch_mask_i      in   NUM_CH    channel enable mask, bit n = channel n
//  clr_i          in   1         clears err_o and overrun_o
//  m_axi_araddr   out  ADDR_W    read address
//  m_axi_arprot   out  3         constant 3'b000
//  m_axi_arvalid  out  1         read address valid
//  m_axi_arready  in   1         read address ready
//  m_axi_rdata    in   32        read data
//  m_axi_rresp    in   2         read response
//  m_axi_rvalid   in   1         read data valid
//  m_axi_rready   out  1         read data ready
//  smp_o          out  SAMPLE_W  sample value
//  smp_ch_o       out  CH_W      channel index of smp_o
//  smp_valid_o    out  1         sample valid
//  smp_ready_i    in   1         sample accepted by sink
//  state_o        out  2         FSM state (IDLE=00 ADDR=01 DATA=10 OUT=11)
//  err_o          out  1         sticky: non-OKAY rresp seen
//  overrun_o      out  1         sticky: trigger arrived while sweep busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latched mask 0, channel 0.
//  Trigger: TRIG_MODE=0 -> en_i & eoc_i in IDLE; TRIG_MODE=1 -> en_i in IDLE. On trigger,
//   ch_mask_i is latched; if latched mask==0 stay IDLE, else select lowest set bit, go ADDR.
//  ADDR: arvalid=1, araddr=CH_BASE+ch*CH_STRIDE (truncate to ADDR_W), held stable until arready;
//   arvalid&arready -> DATA. arvalid first high the cycle after trigger.
//  DATA: rready=1; on rvalid: rresp==00 -> register rdata[15-:SAMPLE_W] into smp_o, ch into
//   smp_ch_o, go OUT; rresp!=00 -> set err_o, drop sample, advance as below.
//  OUT: smp_valid_o=1, smp_o/smp_ch_o stable until smp_ready_i; on handshake (or error drop)
//   next = lowest set latched-mask bit above ch -> ADDR; none -> IDLE.
//  Best-case per channel: ADDR 1 + DATA 1 + OUT 1 = 3 cycles; trigger-to-first-valid = 3 cycles.
//  en_i low mid-sweep: current sweep completes; no new trigger. ch_mask_i changes mid-sweep ignored.
//  eoc_i while state!=IDLE (mode 0): trigger dropped, overrun_o set. Mode 1 never sets overrun.
//  clr_i clears err_o/overrun_o; set event same cycle as clr_i wins (flag ends 1).
//  rst mid-transaction: arvalid/rready/smp_valid_o drop immediately; no outstanding state kept.
//  No AXI timeout; master never withdraws arvalid once asserted.
// TESTING
//  1 Mode 0, mask 4'b0101, arready/rvalid 1-cycle, ready=1: one eoc -> araddr 0x240 then 0x248,
//    samples ch0,ch2, rdata 0xABC0 -> smp_o 0xABC, state returns 00.
//  2 smp_ready_i low 10 cycles in OUT: smp_o/smp_ch_o/smp_valid_o stable, no arvalid issued.
//  3 arready delayed 5 cycles: araddr/arvalid stable throughout, single AR handshake.
//  4 rresp=2'b10 on ch1 of mask 4'b0011: err_o=1, only ch0 sample emitted; clr_i -> err_o=0.
//  5 eoc_i during DATA: overrun_o=1, sweep finishes with original mask, no second sweep.
//  6 Mode 1, mask 0: stays IDLE; rst asserted in ADDR -> arvalid=0 same cycle, state 00.

Source files
------------

// File: rtl/xadc_axil_seq_master.sv
// AXI4-Lite read master sweeping masked XADC channel registers into a tagged sample stream.
// Latency: trigger-to-first-sample 3 cycles best case; 3 cycles per channel.
// Backpressure: sample held in OUT until smp_ready_i; AXI waits on arready/rvalid without timeout.
module xadc_axil_seq_master #(
  parameter int NUM_CH    = 4,
  parameter int CH_BASE   = 'h240,
  parameter int CH_STRIDE = 4,
  parameter int ADDR_W    = 12,
  parameter int SAMPLE_W  = 12,
  parameter int TRIG_MODE = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                eoc_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  input  logic                clr_i,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [31:0]         m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [SAMPLE_W-1:0] smp_o,
  output logic [CH_W-1:0]     smp_ch_o,
  output logic                smp_valid_o,
  input  logic                smp_ready_i,
  output logic [1:0]          state_o,
  output logic                err_o,
  output logic                overrun_o
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ADDR = 2'b01, S_DATA = 2'b10, S_OUT = 2'b11} state_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   mask_q;
  logic [CH_W-1:0]     ch_q;
  logic [SAMPLE_W-1:0] smp_q;
  logic [CH_W-1:0]     smp_ch_q;
  logic                err_q, overrun_q;

  // Returns {found, index} of the lowest set mask bit strictly above 'after'.
  function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] m, input int after);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > after)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  logic [CH_W:0] first_sel, next_sel;
  logic          trig, rd_ok, rd_bad, advance;

  assign first_sel = find_next(ch_mask_i, -1);
  assign next_sel  = find_next(mask_q, int'(ch_q));
  assign trig      = (state == S_IDLE) && en_i && ((TRIG_MODE != 0) || eoc_i);
  assign rd_ok     = (state == S_DATA) && m_axi_rvalid && (m_axi_rresp == 2'b00);
  assign rd_bad    = (state == S_DATA) && m_axi_rvalid && (m_axi_rresp != 2'b00);
  // An errored read skips OUT and moves on exactly like an accepted sample.
  assign advance   = ((state == S_OUT) && smp_ready_i) || rd_bad;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (trig && first_sel[CH_W]) state_nxt = S_ADDR;
      S_ADDR: if (m_axi_arready) state_nxt = S_DATA;
      S_DATA: begin
        if (rd_ok)       state_nxt = S_OUT;
        else if (rd_bad) state_nxt = next_sel[CH_W] ? S_ADDR : S_IDLE;
      end
      S_OUT:  if (smp_ready_i) state_nxt = next_sel[CH_W] ? S_ADDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so reset drops them immediately
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_rready  = 1'b0;
    smp_valid_o   = 1'b0;
    case (state)
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = ADDR_W'(CH_BASE) + ADDR_W'(ch_q) * ADDR_W'(CH_STRIDE);
      end
      S_DATA:  m_axi_rready = 1'b1;
      S_OUT:   smp_valid_o  = 1'b1;
      default: ;
    endcase
  end

  // Sweep bookkeeping: latched mask, current channel, captured sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      ch_q     <= '0;
      smp_q    <= '0;
      smp_ch_q <= '0;
    end else begin
      if (trig) mask_q <= ch_mask_i;
      if (trig && first_sel[CH_W]) ch_q <= first_sel[CH_W-1:0];
      if (rd_ok) begin
        smp_q    <= m_axi_rdata[15 -: SAMPLE_W];
        smp_ch_q <= ch_q;
      end
      if (advance && next_sel[CH_W]) ch_q <= next_sel[CH_W-1:0];
    end
  end

  // Sticky flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (rd_bad)     err_q <= 1'b1;
      else if (clr_i) err_q <= 1'b0;
      if ((TRIG_MODE == 0) && eoc_i && (state != S_IDLE)) overrun_q <= 1'b1;
      else if (clr_i)                                    overrun_q <= 1'b0;
    end
  end

  // Only the sample field of the result register is consumed.
  logic unused_rdata;
  if (SAMPLE_W < 16) begin : g_lo
    assign unused_rdata = ^{m_axi_rdata[31:16], m_axi_rdata[15-SAMPLE_W:0]};
  end else begin : g_nolo
    assign unused_rdata = ^m_axi_rdata[31:16];
  end

  assign m_axi_arprot = 3'b000;
  assign smp_o        = smp_q;
  assign smp_ch_o     = smp_ch_q;
  assign state_o      = state;
  assign err_o        = err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_xadc_axil_seq_master.sv
// Directed bench for xadc_axil_seq_master: mode-0 instance with a negedge AXI slave model,
// plus a mode-1 instance for free-run and reset-in-ADDR checks.
module tb_xadc_axil_seq_master;
  logic        clk = 0;
  logic        rst;
  logic        en, eoc, clr, smp_ready;
  logic [3:0]  mask;
  logic [11:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [11:0] smp;
  logic [1:0]  smp_ch, state;
  logic        smp_valid, err, overrun;

  logic        en1;
  logic [3:0]  mask1;
  logic [11:0] araddr1;
  logic [2:0]  arprot1;
  logic        arvalid1, rready1, smp_valid1, err1, overrun1;
  logic [11:0] smp1;
  logic [1:0]  smp_ch1, state1;

  int checks = 0, failures = 0;

  // slave model configuration and observation
  int          ar_delay = 0, err_ch = -1, ar_wait = 0, rch;
  logic [31:0] rd_base = 0;
  logic        r_pend = 0;
  logic [11:0] r_addr = 0;
  logic [11:0] ar_q[$];
  logic [13:0] smp_q[$];

  always #5 clk = ~clk;

  xadc_axil_seq_master #(.TRIG_MODE(0)) dut (
    .clk(clk), .rst(rst), .en_i(en), .eoc_i(eoc), .ch_mask_i(mask), .clr_i(clr),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .smp_o(smp), .smp_ch_o(smp_ch), .smp_valid_o(smp_valid), .smp_ready_i(smp_ready),
    .state_o(state), .err_o(err), .overrun_o(overrun));

  xadc_axil_seq_master #(.TRIG_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en_i(en1), .eoc_i(eoc), .ch_mask_i(mask1), .clr_i(clr),
    .m_axi_araddr(araddr1), .m_axi_arprot(arprot1), .m_axi_arvalid(arvalid1), .m_axi_arready(1'b0),
    .m_axi_rdata(32'h0), .m_axi_rresp(2'b00), .m_axi_rvalid(1'b0), .m_axi_rready(rready1),
    .smp_o(smp1), .smp_ch_o(smp_ch1), .smp_valid_o(smp_valid1), .smp_ready_i(1'b1),
    .state_o(state1), .err_o(err1), .overrun_o(overrun1));

  // AXI slave and stream monitor: drive on negedge, record handshakes that land on the next posedge
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; r_pend = 0; ar_wait = 0;
      end else begin
        arready = arvalid && (ar_wait >= ar_delay);
        rvalid  = r_pend;
        rch     = (int'(r_addr) - 'h240) / 4;
        rdata   = rd_base + 32'(rch * 16);
        rresp   = (rch == err_ch) ? 2'b10 : 2'b00;
        if (rvalid && rready) r_pend = 0;
        if (arvalid && arready) begin
          ar_q.push_back(araddr); r_pend = 1; r_addr = araddr; ar_wait = 0;
        end else if (arvalid) ar_wait++;
        if (smp_valid && smp_ready) smp_q.push_back({smp_ch, smp});
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (state !== 2'b00 && n < 40) begin tick(); n++; end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL %s_timeout state=%0h exp=0", name, state); end
  endtask

  task automatic start_sweep;
    eoc = 1; tick(); eoc = 0;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL rst_state got=%0h exp=0", state); end
    checks++; if ({arvalid, rready, smp_valid} !== 3'b000) begin failures++; $display("FAIL rst_valids got=%b exp=000", {arvalid, rready, smp_valid}); end
    checks++; if ({araddr, arprot, smp, smp_ch} !== 29'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {araddr, arprot, smp, smp_ch}); end
    checks++; if ({err, overrun} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {err, overrun}); end
    rst = 0; tick();
  endtask

  task automatic test_basic;
    ar_q.delete(); smp_q.delete(); rd_base = 32'hABC0; mask = 4'b0101; smp_ready = 1;
    start_sweep();
    checks++; if (state !== 2'b01 || arvalid !== 1'b1 || araddr !== 12'h240) begin failures++; $display("FAIL t1_addr state=%0h arvalid=%b araddr=%h exp 1/1/240", state, arvalid, araddr); end
    tick();
    checks++; if (state !== 2'b10 || rready !== 1'b1) begin failures++; $display("FAIL t1_data state=%0h rready=%b exp 2/1", state, rready); end
    tick();
    checks++; if (smp_valid !== 1'b1 || smp !== 12'hABC || smp_ch !== 2'd0) begin failures++; $display("FAIL t1_first_smp valid=%b smp=%h ch=%0d exp 1/abc/0", smp_valid, smp, smp_ch); end
    wait_idle("t1");
    checks++; if (ar_q.size() != 2 || ar_q[0] !== 12'h240 || ar_q[1] !== 12'h248) begin failures++; $display("FAIL t1_ar_seq n=%0d exp 240,248", ar_q.size()); end
    checks++; if (smp_q.size() != 2 || smp_q[0] !== {2'd0, 12'hABC} || smp_q[1] !== {2'd2, 12'hABE}) begin failures++; $display("FAIL t1_smp_seq n=%0d exp ch0:abc ch2:abe", smp_q.size()); end
  endtask

  task automatic test_backpressure;
    ar_q.delete(); smp_q.delete(); rd_base = 32'h1230; mask = 4'b0001; smp_ready = 0;
    start_sweep(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if (smp_valid !== 1'b1 || smp !== 12'h123 || smp_ch !== 2'd0 || arvalid !== 1'b0) begin
        failures++; $display("FAIL t2_hold cyc=%0d valid=%b smp=%h ch=%0d arvalid=%b exp 1/123/0/0", i, smp_valid, smp, smp_ch, arvalid); end
      tick();
    end
    smp_ready = 1; tick();
    checks++; if (state !== 2'b00 || smp_q.size() != 1 || ar_q.size() != 1) begin failures++; $display("FAIL t2_done state=%0h nsmp=%0d nar=%0d exp 0/1/1", state, smp_q.size(), ar_q.size()); end
  endtask

  task automatic test_ar_delay;
    ar_q.delete(); smp_q.delete(); rd_base = 32'h3000; mask = 4'b0010; ar_delay = 5;
    start_sweep();
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== 2'b01 || arvalid !== 1'b1 || araddr !== 12'h244) begin
        failures++; $display("FAIL t3_hold cyc=%0d state=%0h arvalid=%b araddr=%h exp 1/1/244", i, state, arvalid, araddr); end
      tick();
    end
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL t3_to_data state=%0h exp=2", state); end
    wait_idle("t3"); ar_delay = 0;
    checks++; if (ar_q.size() != 1 || ar_q[0] !== 12'h244) begin failures++; $display("FAIL t3_single_ar n=%0d exp 1 at 244", ar_q.size()); end
    checks++; if (smp_q.size() != 1 || smp_q[0] !== {2'd1, 12'h301}) begin failures++; $display("FAIL t3_smp n=%0d exp ch1:301", smp_q.size()); end
  endtask

  task automatic test_rresp_err;
    ar_q.delete(); smp_q.delete(); rd_base = 32'h5550; mask = 4'b0011; err_ch = 1;
    start_sweep(); wait_idle("t4"); err_ch = -1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL t4_err got=%b exp=1", err); end
    checks++; if (ar_q.size() != 2) begin failures++; $display("FAIL t4_nar got=%0d exp=2", ar_q.size()); end
    checks++; if (smp_q.size() != 1 || smp_q[0] !== {2'd0, 12'h555}) begin failures++; $display("FAIL t4_smp n=%0d exp ch0:555 only", smp_q.size()); end
    clr = 1; tick(); clr = 0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t4_clr got=%b exp=0", err); end
  endtask

  task automatic test_overrun;
    ar_q.delete(); smp_q.delete(); rd_base = 32'h7770; mask = 4'b0101;
    start_sweep();
    mask = 4'b1111;
    tick();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t5_pre got=%b exp=0", overrun); end
    eoc = 1; tick(); eoc = 0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t5_overrun got=%b exp=1", overrun); end
    wait_idle("t5");
    tick(); tick(); tick();
    checks++; if (state !== 2'b00 || ar_q.size() != 2 || ar_q[0] !== 12'h240 || ar_q[1] !== 12'h248) begin failures++; $display("FAIL t5_sweep state=%0h nar=%0d exp 0/2 (240,248)", state, ar_q.size()); end
    checks++; if (smp_q.size() != 2 || smp_q[0] !== {2'd0, 12'h777} || smp_q[1] !== {2'd2, 12'h779}) begin failures++; $display("FAIL t5_smp n=%0d exp ch0:777 ch2:779", smp_q.size()); end
    clr = 1; tick(); clr = 0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t5_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_mode1_reset;
    en1 = 1; mask1 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (state1 !== 2'b00 || arvalid1 !== 1'b0) begin failures++; $display("FAIL t6_mask0 state=%0h arvalid=%b exp 0/0", state1, arvalid1); end
    end
    mask1 = 4'b0001; tick();
    checks++; if (state1 !== 2'b01 || arvalid1 !== 1'b1 || araddr1 !== 12'h240) begin failures++; $display("FAIL t6_addr state=%0h arvalid=%b araddr=%h exp 1/1/240", state1, arvalid1, araddr1); end
    eoc = 1; tick(); eoc = 0; tick();
    checks++; if (overrun1 !== 1'b0 || state1 !== 2'b01) begin failures++; $display("FAIL t6_no_overrun ovr=%b state=%0h exp 0/1", overrun1, state1); end
    #2 rst = 1; #1;
    checks++; if (arvalid1 !== 1'b0 || state1 !== 2'b00) begin failures++; $display("FAIL t6_rst arvalid=%b state=%0h exp 0/0", arvalid1, state1); end
    en1 = 0; tick(); rst = 0; tick();
  endtask

  initial begin
    rst = 1; en = 1; eoc = 0; clr = 0; smp_ready = 1; mask = 4'b0000; en1 = 0; mask1 = 4'b0000;
    test_reset();
    test_basic();
    test_backpressure();
    test_ar_delay();
    test_rresp_err();
    test_overrun();
    test_mode1_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
